// File: rtl/mem_access_unit.sv
// EX/MEM memory access unit: drives the D-cache request/response handshake,
// forms byte strobes and lane-replicated store data, and extends load results.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_req_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic        fc_flush_i,
    output logic        dc_req_o,
    output logic [31:0] dc_addr_o,
    output logic        dc_we_o,
    output logic [3:0]  dc_wstrb_o,
    output logic [31:0] dc_wdata_o,
    input  logic        dc_gnt_i,
    input  logic        dc_rvalid_i,
    input  logic [31:0] dc_rdata_i,
    output logic        mau_stall_o,
    output logic [31:0] mau_ld_data_o,
    output logic        mau_ld_valid_o,
    output logic        mau_misalign_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e      state_q;
    logic [1:0]  width_q;
    logic [1:0]  off_q;
    logic        rdtype_q;
    logic        flushed_q;

    logic        misaligned;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic        resp_flushed;

    always_comb begin
        misaligned = 1'b0;
        case (ex_mem_width_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_mem_addr_i[0];
            default: misaligned = |ex_mem_addr_i[1:0];
        endcase
    end

    always_comb begin
        req_wstrb = 4'b0000;
        req_wdata = 32'h0;
        if (ex_mem_rw_i) begin
            case (ex_mem_width_i)
                2'b00: begin
                    req_wstrb = 4'b0001 << ex_mem_addr_i[1:0];
                    req_wdata = {4{ex_mem_wr_data_i[7:0]}};
                end
                2'b01: begin
                    req_wstrb = 4'b0011 << ex_mem_addr_i[1:0];
                    req_wdata = {2{ex_mem_wr_data_i[15:0]}};
                end
                default: begin
                    req_wstrb = 4'b1111;
                    req_wdata = ex_mem_wr_data_i;
                end
            endcase
        end
    end

    // Accesses are aligned, so one shift by the byte offset lands any lane at bit 0.
    assign ld_shift = dc_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (width_q)
            2'b00:   ld_ext = {{24{~rdtype_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = {{16{~rdtype_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign resp_flushed = flushed_q | fc_flush_i;

    assign mau_stall_o = ((state_q == StIdle) & ex_mem_req_i & ~misaligned & ~fc_flush_i)
                       | (state_q == StReq) | (state_q == StResp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            width_q        <= 2'b00;
            off_q          <= 2'b00;
            rdtype_q       <= 1'b0;
            flushed_q      <= 1'b0;
            dc_req_o       <= 1'b0;
            dc_addr_o      <= 32'h0;
            dc_we_o        <= 1'b0;
            dc_wstrb_o     <= 4'b0000;
            dc_wdata_o     <= 32'h0;
            mau_ld_data_o  <= 32'h0;
            mau_ld_valid_o <= 1'b0;
            mau_misalign_o <= 1'b0;
        end else begin
            mau_ld_valid_o <= 1'b0;
            mau_misalign_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ex_mem_req_i && !fc_flush_i) begin
                        if (misaligned) begin
                            mau_misalign_o <= 1'b1;
                        end else begin
                            state_q    <= StReq;
                            dc_req_o   <= 1'b1;
                            dc_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
                            dc_we_o    <= ex_mem_rw_i;
                            dc_wstrb_o <= req_wstrb;
                            dc_wdata_o <= req_wdata;
                            width_q    <= ex_mem_width_i;
                            off_q      <= ex_mem_addr_i[1:0];
                            rdtype_q   <= ex_mem_rdtype_i;
                            flushed_q  <= 1'b0;
                        end
                    end
                end
                StReq: begin
                    // A grant beats a same-cycle flush; the access then completes flushed.
                    if (dc_gnt_i) begin
                        dc_req_o  <= 1'b0;
                        state_q   <= StResp;
                        flushed_q <= fc_flush_i;
                    end else if (fc_flush_i) begin
                        dc_req_o <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StResp: begin
                    flushed_q <= resp_flushed;
                    if (dc_rvalid_i) begin
                        state_q <= StDone;
                        if (!dc_we_o && !resp_flushed) begin
                            mau_ld_valid_o <= 1'b1;
                            mau_ld_data_o  <= ld_ext;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model of the access rules.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_mem_req_i;
    logic [31:0] ex_mem_addr_i;
    logic        ex_mem_rw_i;
    logic [1:0]  ex_mem_width_i;
    logic        ex_mem_rdtype_i;
    logic [31:0] ex_mem_wr_data_i;
    logic        fc_flush_i;
    logic        dc_req_o;
    logic [31:0] dc_addr_o;
    logic        dc_we_o;
    logic [3:0]  dc_wstrb_o;
    logic [31:0] dc_wdata_o;
    logic        dc_gnt_i;
    logic        dc_rvalid_i;
    logic [31:0] dc_rdata_i;
    logic        mau_stall_o;
    logic [31:0] mau_ld_data_o;
    logic        mau_ld_valid_o;
    logic        mau_misalign_o;

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_mem_req_i     (ex_mem_req_i),
        .ex_mem_addr_i    (ex_mem_addr_i),
        .ex_mem_rw_i      (ex_mem_rw_i),
        .ex_mem_width_i   (ex_mem_width_i),
        .ex_mem_rdtype_i  (ex_mem_rdtype_i),
        .ex_mem_wr_data_i (ex_mem_wr_data_i),
        .fc_flush_i       (fc_flush_i),
        .dc_req_o         (dc_req_o),
        .dc_addr_o        (dc_addr_o),
        .dc_we_o          (dc_we_o),
        .dc_wstrb_o       (dc_wstrb_o),
        .dc_wdata_o       (dc_wdata_o),
        .dc_gnt_i         (dc_gnt_i),
        .dc_rvalid_i      (dc_rvalid_i),
        .dc_rdata_i       (dc_rdata_i),
        .mau_stall_o      (mau_stall_o),
        .mau_ld_data_o    (mau_ld_data_o),
        .mau_ld_valid_o   (mau_ld_valid_o),
        .mau_misalign_o   (mau_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one outstanding access described by what is still owed to the cache.
    bit          m_valid = 0;
    bit          m_req, m_wait_rsp, m_finish, m_flushed, m_after_rst;
    bit          m_we;
    logic [1:0]  m_width, m_off;
    bit          m_rdtype;
    logic [31:0] m_addr, m_wdata, m_ld_data;
    logic [3:0]  m_wstrb;
    bit          m_ld_valid, m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd0) return 1'b0;
        if (w == 2'd1) return a % 2 != 0;
        return a % 4 != 0;
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] w, input logic [1:0] off,
                                            input bit zext, input logic [31:0] rd);
        logic [31:0] v;
        if (w >= 2'd2) return rd;
        if (w == 2'd1) begin
            v = (rd >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (!zext && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = (rd >> (8 * int'(off))) & 32'hFF;
            if (!zext && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic bit model_stall();
        bit idle;
        idle = !m_req && !m_wait_rsp && !m_finish;
        return (idle && ex_mem_req_i && !fc_flush_i
                && !is_misaligned(ex_mem_width_i, ex_mem_addr_i)) || m_req || m_wait_rsp;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_valid = 1; m_req = 0; m_wait_rsp = 0; m_finish = 0; m_flushed = 0;
            m_addr = 0; m_we = 0; m_wstrb = 0; m_wdata = 0; m_ld_data = 0;
            m_ld_valid = 0; m_mis = 0; m_after_rst = 1;
            return;
        end
        m_after_rst = 0;
        m_ld_valid = 0;
        m_mis = 0;
        if (m_finish) begin
            m_finish = 0;
        end else if (m_req) begin
            if (dc_gnt_i) begin
                m_req = 0; m_wait_rsp = 1; m_flushed = fc_flush_i;
            end else if (fc_flush_i) begin
                m_req = 0;
            end
        end else if (m_wait_rsp) begin
            m_flushed = m_flushed || fc_flush_i;
            if (dc_rvalid_i) begin
                m_wait_rsp = 0;
                m_finish = 1;
                if (!m_we && !m_flushed) begin
                    m_ld_valid = 1;
                    m_ld_data = extract(m_width, m_off, m_rdtype, dc_rdata_i);
                end
            end
        end else if (ex_mem_req_i && !fc_flush_i) begin
            if (is_misaligned(ex_mem_width_i, ex_mem_addr_i)) begin
                m_mis = 1;
            end else begin
                m_req = 1;
                m_addr = ex_mem_addr_i & ~32'h3;
                m_we = ex_mem_rw_i;
                m_width = ex_mem_width_i;
                m_off = ex_mem_addr_i[1:0];
                m_rdtype = ex_mem_rdtype_i;
                m_flushed = 0;
                if (!ex_mem_rw_i) begin
                    m_wstrb = 4'h0;
                    m_wdata = 32'h0;
                end else if (ex_mem_width_i == 2'd0) begin
                    m_wstrb = 4'(32'd1 << m_off);
                    m_wdata = {24'h0, ex_mem_wr_data_i[7:0]} * 32'h0101_0101;
                end else if (ex_mem_width_i == 2'd1) begin
                    m_wstrb = 4'(32'd3 << m_off);
                    m_wdata = {16'h0, ex_mem_wr_data_i[15:0]} * 32'h0001_0001;
                end else begin
                    m_wstrb = 4'hF;
                    m_wdata = ex_mem_wr_data_i;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("dc_req", dc_req_o, m_req);
        if (m_req || m_after_rst) begin
            check("dc_addr", dc_addr_o, m_addr);
            check("dc_we", dc_we_o, m_we);
            check("dc_wstrb", dc_wstrb_o, m_wstrb);
            if (m_we || m_after_rst) check("dc_wdata", dc_wdata_o, m_wdata);
        end
        check("ld_valid", mau_ld_valid_o, m_ld_valid);
        check("misalign", mau_misalign_o, m_mis);
        check("ld_data", mau_ld_data_o, m_ld_data);
    endtask

    // One clock cycle: drive on the falling edge, check stall before the rising
    // edge, advance the model on the rising edge, compare registered outputs after.
    task automatic step(input logic rst, input logic req, input logic [31:0] addr,
                        input logic rw, input logic [1:0] width, input logic rdtype,
                        input logic [31:0] wd, input logic flush, input logic gnt,
                        input logic rvalid, input logic [31:0] rdata);
        @(negedge clk);
        rst_n = rst; ex_mem_req_i = req; ex_mem_addr_i = addr; ex_mem_rw_i = rw;
        ex_mem_width_i = width; ex_mem_rdtype_i = rdtype; ex_mem_wr_data_i = wd;
        fc_flush_i = flush; dc_gnt_i = gnt; dc_rvalid_i = rvalid; dc_rdata_i = rdata;
        #2;
        if (m_valid) check("stall", mau_stall_o, model_stall());
        @(posedge clk);
        model_update();
        #1;
        compare_outputs();
    endtask

    task automatic idle_cycle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int          rsp_delay;
    logic        r_rst, r_req, r_rw, r_rdtype, r_flush, r_gnt, r_rv, req_was;
    logic [1:0]  r_width;
    logic [31:0] r_addr, r_wd, r_rd;

    initial begin
        rst_n = 0; ex_mem_req_i = 0; ex_mem_addr_i = 0; ex_mem_rw_i = 0;
        ex_mem_width_i = 0; ex_mem_rdtype_i = 0; ex_mem_wr_data_i = 0;
        fc_flush_i = 0; dc_gnt_i = 0; dc_rvalid_i = 0; dc_rdata_i = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lit_reset_req", dc_req_o, 0);
        check("lit_reset_ld_data", mau_ld_data_o, 0);
        idle_cycle();

        // Signed byte load, minimum latency.
        step(1, 1, 32'h1003, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        check("lit_lb_addr", dc_addr_o, 32'h1000);
        check("lit_lb_wstrb", dc_wstrb_o, 4'b0000);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        check("lit_lb_valid", mau_ld_valid_o, 1);
        check("lit_lb_data", mau_ld_data_o, 32'hFFFF_FF80);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lit_lb_done_stall", mau_stall_o, 0);
        idle_cycle();

        // Half store with grant delayed three cycles.
        step(1, 1, 32'h2002, 1, 2'd1, 0, 32'h0000_BEEF, 0, 0, 0, 0);
        check("lit_sh_wstrb", dc_wstrb_o, 4'b1100);
        check("lit_sh_wdata", dc_wdata_o, 32'hBEEF_BEEF);
        check("lit_sh_we", dc_we_o, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("lit_sh_req_held", dc_req_o, 1);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("lit_sh_req_drop", dc_req_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
        check("lit_sh_no_ldv", mau_ld_valid_o, 0);
        idle_cycle();
        idle_cycle();

        // Misaligned word.
        step(1, 1, 32'h3001, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        check("lit_mis_pulse", mau_misalign_o, 1);
        check("lit_mis_stall", mau_stall_o, 0);
        check("lit_mis_noreq", dc_req_o, 0);
        idle_cycle();

        // Flush before grant, then flush while awaiting response.
        step(1, 1, 32'h5000, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("lit_flush_req_drop", dc_req_o, 0);
        idle_cycle();
        step(1, 1, 32'h6000, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        check("lit_flush_no_ldv", mau_ld_valid_o, 0);
        check("lit_flush_hold", mau_ld_data_o, 32'hFFFF_FF80);
        idle_cycle();

        // Unsigned half load; request during the result cycle is dropped, next one taken.
        step(1, 1, 32'h4002, 0, 2'd1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0000);
        check("lit_lhu_data", mau_ld_data_o, 32'h0000_A5A5);
        step(1, 1, 32'h7000, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        check("lit_done_req_ignored", dc_req_o, 0);
        step(1, 1, 32'h7004, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        check("lit_b2b_req", dc_req_o, 1);
        check("lit_b2b_addr", dc_addr_o, 32'h7004);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        check("lit_b2b_data", mau_ld_data_o, 32'hCAFE_F00D);
        idle_cycle();

        // Reset while awaiting response; the late response is ignored.
        step(1, 1, 32'h8000, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lit_rst_ld_data", mau_ld_data_o, 0);
        check("lit_rst_addr", dc_addr_o, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        check("lit_rst_late_rvalid", mau_ld_valid_o, 0);
        idle_cycle();

        // Randomized traffic with a cache that grants and responds at random delays.
        rsp_delay = 0;
        for (int n = 0; n < 4000; n++) begin
            r_rst = ($urandom_range(0, 199) != 0);
            r_req = ($urandom_range(0, 2) == 0);
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            r_rw = 1'($urandom_range(0, 1));
            r_width = 2'($urandom_range(0, 3));
            r_rdtype = 1'($urandom_range(0, 1));
            r_wd = $urandom;
            r_flush = ($urandom_range(0, 11) == 0);
            r_gnt = dc_req_o && ($urandom_range(0, 1) == 1);
            r_rv = (rsp_delay == 1);
            if (rsp_delay > 0) rsp_delay--;
            r_rd = $urandom;
            req_was = dc_req_o;
            step(r_rst, r_req, r_addr, r_rw, r_width, r_rdtype, r_wd, r_flush, r_gnt, r_rv,
                 r_rd);
            if (r_rst && r_gnt && req_was) rsp_delay = $urandom_range(1, 3);
            if (!r_rst && $urandom_range(0, 1) == 1) rsp_delay = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the ID/EX pipeline register, in the EX/MEM boundary.
- Consumes the one-cycle D-cache request pulse plus memory controls (width, rw, rdtype, store data) and the ALU-computed address.
- Runs the request/response handshake with the D-cache, generates byte strobes and aligned store data, and sign- or zero-extends load data.
- Asserts a stall to flow control while an access is outstanding.

Parameters:
- None. Datapath is fixed at 32 bits.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
ex_mem_req_i  in  1  one-cycle access request pulse (from idex_mem_req_Dcache_o)
ex_mem_addr_i  in  32  byte address from ALU, valid with ex_mem_req_i
ex_mem_rw_i  in  1  1=store, 0=load
ex_mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
ex_mem_rdtype_i  in  1  0=sign-extend load, 1=zero-extend load
ex_mem_wr_data_i  in  32  store data, LSBs significant
fc_flush_i  in  1  flush from flow control
dc_req_o  out  1  D-cache request
dc_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
dc_we_o  out  1  write enable
dc_wstrb_o  out  4  byte strobes
dc_wdata_o  out  32  lane-replicated store data
dc_gnt_i  in  1  D-cache accepts the request this cycle
dc_rvalid_i  in  1  access complete, for loads and stores
dc_rdata_i  in  32  read word, valid with dc_rvalid_i
mau_stall_o  out  1  hold request to flow control
mau_ld_data_o  out  32  extended load result
mau_ld_valid_o  out  1  one-cycle pulse, load result valid
mau_misalign_o  out  1  one-cycle pulse, misaligned access rejected

Behaviour:
- Reset:
  - Sync reset with rst_n=0 forces state IDLE.
  - All registered outputs reset to 0: dc_req_o, dc_addr_o, dc_we_o, dc_wstrb_o, dc_wdata_o, mau_ld_data_o, mau_ld_valid_o, mau_misalign_o.
  - Reset overrides any in-flight access, including a granted one. Late dc_rvalid_i after reset is ignored in IDLE.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - On ex_mem_req_i with fc_flush_i=0, capture addr, rw, width, rdtype and wdata.
  - Misalign check: half with addr[0]=1, or word (incl. width 11) with addr[1:0]!=0.
  - Misaligned: stay IDLE, pulse mau_misalign_o next cycle, no D-cache request.
  - Aligned: go to REQ; dc_req_o=1 from the next cycle.
- REQ:
  - dc_req_o held high with stable addr, we, wstrb and wdata until dc_gnt_i=1.
  - On grant: go to RESP, drop dc_req_o next cycle.
  - If fc_flush_i=1 and dc_gnt_i=0: abort to IDLE, dc_req_o=0 next cycle. Grant in the same cycle as flush wins: go to RESP, marked flushed.
- RESP:
  - Wait for dc_rvalid_i, then go to DONE. dc_rvalid_i in the grant cycle is not accepted.
  - fc_flush_i seen in REQ or RESP sets a sticky flushed flag. The access still completes; only the load result is suppressed.
- DONE, one cycle, then IDLE:
  - mau_ld_valid_o=1 only if the access is a load and not flushed.
  - mau_ld_data_o is updated only when mau_ld_valid_o pulses; otherwise it holds its value.
  - A new ex_mem_req_i in DONE is ignored. Upstream is still held until this cycle.
- Stall, combinational: mau_stall_o = (IDLE & ex_mem_req_i & aligned & !fc_flush_i) | REQ | RESP. It is low in DONE, so the pipeline advances in the cycle the result appears.
- Strobes and store data (s = addr[1:0]):
  - Byte: wstrb = 0001<<s, wdata = {4{d[7:0]}}.
  - Half: wstrb = 0011<<s, wdata = {2{d[15:0]}}.
  - Word: wstrb = 1111, wdata = d.
  - Loads: dc_we_o=0, wstrb=0000.
- Load extraction:
  - Byte lane = rdata[8s+7:8s]; half lane = rdata[16*addr[1]+15:16*addr[1]].
  - Sign- or zero-extend per rdtype. Word passes through.
  - The lane is registered into mau_ld_data_o on dc_rvalid_i.
- Minimum latency: request at cycle 0, dc_req_o at 1, grant at 1, rvalid at 2, ld_valid at 3.

Test Plan:
- Load byte, signed: addr=0x1003, rdtype=0, immediate gnt, rvalid next cycle with rdata=0x80FF_0000 -> dc_addr_o=0x1000, wstrb=0000, mau_ld_data_o=0xFFFF_FF80 with ld_valid at cycle 3; stall high cycles 0-2.
- Store half: addr=0x2002, wr_data=0x0000_BEEF, gnt delayed 3 cycles -> dc_req_o held 4 cycles with wstrb=1100, wdata=0xBEEF_BEEF, we=1; no ld_valid; stall drops in DONE.
- Misaligned word: addr=0x3001 -> no dc_req_o, mau_misalign_o pulse next cycle, mau_stall_o never high.
- Flush in REQ before grant -> dc_req_o drops next cycle, IDLE, no ld_valid. Flush in RESP on a load, rvalid with 0x1234_5678 -> DONE, ld_valid=0, ld_data unchanged.
- Load half unsigned: addr=0x4002, rdata=0xA5A5_0000 -> mau_ld_data_o=0x0000_A5A5. Back-to-back request issued the cycle after DONE -> accepted normally.
- rst_n=0 while in RESP -> IDLE, all outputs 0 next edge; later dc_rvalid_i ignored, no ld_valid.
